// File: rtl/b10b_align_sync.sv
// rtl/b10b_align_sync.sv - K28.5 comma aligner and sync state machine for the 10b receive path
module b10b_align_sync #(
  parameter int LOCK_COMMAS = 3,
  parameter int LOSS_ERRS   = 4,
  parameter int GOOD_RUN    = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] raw_data,
  input  logic       raw_valid,
  input  logic       realign,
  output logic [9:0] aligned_word,
  output logic       aligned_valid,
  output logic       is_comma,
  output logic       code_err,
  output logic       sync,
  output logic [3:0] align_offset
);

  typedef enum logic [1:0] {
    HUNT    = 2'd0,
    CONFIRM = 2'd1,
    LOCKED  = 2'd2
  } state_t;

  localparam logic [9:0] COMMA_NEG = 10'b0011111010;
  localparam logic [9:0] COMMA_POS = 10'b1100000101;
  localparam logic [4:0] LOCK_N    = 5'(LOCK_COMMAS);
  localparam logic [4:0] LOSS_N    = 5'(LOSS_ERRS);
  localparam logic [4:0] GOOD_N    = 5'(GOOD_RUN);

  state_t     state_q, state_d;
  logic [9:0] prev_q, prev_d;
  logic [3:0] offset_q, offset_d;
  logic [3:0] ccnt_q, ccnt_d;
  logic [3:0] ecnt_q, ecnt_d;
  logic [3:0] gcnt_q, gcnt_d;
  logic [9:0] aligned_word_q, aligned_word_d;
  logic       aligned_valid_q, aligned_valid_d;
  logic       is_comma_q, is_comma_d;
  logic       code_err_q, code_err_d;

  logic [19:0] window;
  logic [9:0]  cand [0:9];
  logic [9:0]  comma_vec;
  logic [9:0]  valid_vec;
  logic        any_comma;
  logic [3:0]  first_k;
  logic [4:0]  ccnt_inc, ecnt_inc, gcnt_inc;
  logic        comma_at_off, valid_at_off, locked_err;

  // The window spans the previous and current beat; offset 0 is the previous beat itself.
  assign window = {prev_q, raw_data};

  // Extract all ten candidates and classify each as comma and/or plausible codeword.
  always_comb begin
    for (int k = 0; k < 10; k++) begin
      cand[k]      = window[19-k -: 10];
      comma_vec[k] = (cand[k] == COMMA_NEG) || (cand[k] == COMMA_POS);
      valid_vec[k] = ($countones(cand[k]) >= 4) && ($countones(cand[k]) <= 6);
    end
  end

  // Priority-encode the lowest offset holding a comma so ties always resolve the same way.
  always_comb begin
    first_k   = 4'd0;
    any_comma = |comma_vec;
    for (int k = 9; k >= 0; k--) begin
      if (comma_vec[k]) begin
        first_k = 4'(k);
      end
    end
  end

  assign ccnt_inc     = {1'b0, ccnt_q} + 5'd1;
  assign ecnt_inc     = {1'b0, ecnt_q} + 5'd1;
  assign gcnt_inc     = {1'b0, gcnt_q} + 5'd1;
  assign comma_at_off = comma_vec[offset_q];
  assign valid_at_off = valid_vec[offset_q];
  assign locked_err   = !valid_at_off || (!comma_at_off && any_comma);

  // Next-state and registered-output logic for HUNT / CONFIRM / LOCKED.
  always_comb begin
    state_d         = state_q;
    prev_d          = prev_q;
    offset_d        = offset_q;
    ccnt_d          = ccnt_q;
    ecnt_d          = ecnt_q;
    gcnt_d          = gcnt_q;
    aligned_word_d  = aligned_word_q;
    is_comma_d      = is_comma_q;
    aligned_valid_d = 1'b0;
    code_err_d      = 1'b0;

    if (raw_valid) begin
      prev_d         = raw_data;
      aligned_word_d = cand[offset_q];
      is_comma_d     = comma_at_off;
      case (state_q)
        HUNT: begin
          if (any_comma) begin
            offset_d       = first_k;
            aligned_word_d = cand[first_k];
            is_comma_d     = 1'b1;
            ccnt_d         = 4'd1;
            if (LOCK_N == 5'd1) begin
              state_d         = LOCKED;
              ecnt_d          = 4'd0;
              gcnt_d          = 4'd0;
              aligned_valid_d = 1'b1;
            end else begin
              state_d = CONFIRM;
            end
          end
        end
        CONFIRM: begin
          if (comma_at_off) begin
            ccnt_d = ccnt_inc[3:0];
            if (ccnt_inc == LOCK_N) begin
              state_d         = LOCKED;
              ecnt_d          = 4'd0;
              gcnt_d          = 4'd0;
              aligned_valid_d = 1'b1;
            end
          end else if (any_comma) begin
            // Boundary moved before lock: restart the count at the new offset.
            offset_d = first_k;
            ccnt_d   = 4'd1;
          end else if (!valid_at_off) begin
            code_err_d = 1'b1;
            state_d    = HUNT;
            ccnt_d     = 4'd0;
          end
        end
        LOCKED: begin
          // The beat that loses sync is still presented downstream.
          aligned_valid_d = 1'b1;
          if (locked_err) begin
            code_err_d = 1'b1;
            ecnt_d     = ecnt_inc[3:0];
            gcnt_d     = 4'd0;
            if (ecnt_inc == LOSS_N) begin
              state_d = HUNT;
              ccnt_d  = 4'd0;
              ecnt_d  = 4'd0;
            end
          end else if (gcnt_inc == GOOD_N) begin
            gcnt_d = 4'd0;
            if (ecnt_q != 4'd0) begin
              ecnt_d = ecnt_q - 4'd1;
            end
          end else begin
            gcnt_d = gcnt_inc[3:0];
          end
        end
        default: begin
          state_d = HUNT;
        end
      endcase
    end

    // Realign wins over whatever the beat decided, but the window history is kept.
    if (realign) begin
      state_d         = HUNT;
      ccnt_d          = 4'd0;
      ecnt_d          = 4'd0;
      gcnt_d          = 4'd0;
      aligned_valid_d = 1'b0;
      code_err_d      = 1'b0;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= HUNT;
      prev_q          <= 10'd0;
      offset_q        <= 4'd0;
      ccnt_q          <= 4'd0;
      ecnt_q          <= 4'd0;
      gcnt_q          <= 4'd0;
      aligned_word_q  <= 10'd0;
      aligned_valid_q <= 1'b0;
      is_comma_q      <= 1'b0;
      code_err_q      <= 1'b0;
    end else begin
      state_q         <= state_d;
      prev_q          <= prev_d;
      offset_q        <= offset_d;
      ccnt_q          <= ccnt_d;
      ecnt_q          <= ecnt_d;
      gcnt_q          <= gcnt_d;
      aligned_word_q  <= aligned_word_d;
      aligned_valid_q <= aligned_valid_d;
      is_comma_q      <= is_comma_d;
      code_err_q      <= code_err_d;
    end
  end

  assign aligned_word  = aligned_word_q;
  assign aligned_valid = aligned_valid_q;
  assign is_comma      = is_comma_q;
  assign code_err      = code_err_q;
  assign sync          = (state_q == LOCKED);
  assign align_offset  = offset_q;

endmodule

// File: tb/tb_b10b_align_sync.sv
// tb/tb_b10b_align_sync.sv - directed bench for b10b_align_sync
module tb_b10b_align_sync;

  logic       clk;
  logic       rst;
  logic [9:0] raw_data;
  logic       raw_valid;
  logic       realign;
  logic [9:0] aligned_word;
  logic       aligned_valid;
  logic       is_comma;
  logic       code_err;
  logic       sync;
  logic [3:0] align_offset;

  int checks = 0;
  int errors = 0;

  localparam logic [9:0] C = 10'h0FA;  // K28.5 RD-
  localparam logic [9:0] D = 10'h2AA;  // D21.5
  localparam logic [9:0] E = 10'h3FF;  // invalid
  localparam logic [9:0] Y = 10'h2A7;  // valid, ends 00111
  localparam logic [9:0] Z = 10'h347;  // comma stream shifted by 5 bits

  logic [9:0] last_sym;

  b10b_align_sync dut (
    .clk          (clk),
    .rst          (rst),
    .raw_data     (raw_data),
    .raw_valid    (raw_valid),
    .realign      (realign),
    .aligned_word (aligned_word),
    .aligned_valid(aligned_valid),
    .is_comma     (is_comma),
    .code_err     (code_err),
    .sync         (sync),
    .align_offset (align_offset)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic beat(input logic [9:0] d, input logic ra);
    @(negedge clk);
    raw_data  = d;
    raw_valid = 1'b1;
    realign   = ra;
    @(posedge clk);
    #1;
    raw_valid = 1'b0;
    realign   = 1'b0;
  endtask

  task automatic idle();
    @(negedge clk);
    raw_valid = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // Serial stream delayed by 3 bits: each beat straddles two symbols.
  task automatic send_sym(input logic [9:0] sym);
    beat({last_sym[2:0], sym[9:3]}, 1'b0);
    last_sym = sym;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    last_sym = 10'd0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_word"}, aligned_word, 10'd0);
    check({tag, "_av"}, aligned_valid, 1'b0);
    check({tag, "_comma"}, is_comma, 1'b0);
    check({tag, "_err"}, code_err, 1'b0);
    check({tag, "_sync"}, sync, 1'b0);
    check({tag, "_off"}, align_offset, 4'd0);
  endtask

  initial begin
    rst       = 1'b1;
    raw_data  = 10'd0;
    raw_valid = 1'b0;
    realign   = 1'b0;
    last_sym  = 10'd0;
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst = 1'b0;

    // Aligned commas: the first beat only loads the window history.
    beat(C, 1'b0);
    beat(C, 1'b0);
    beat(C, 1'b0);
    check("t1_sync_before", sync, 1'b0);
    beat(C, 1'b0);
    check("t1_sync", sync, 1'b1);
    check("t1_off", align_offset, 4'd0);
    check("t1_word", aligned_word, C);
    check("t1_comma", is_comma, 1'b1);
    check("t1_av", aligned_valid, 1'b1);
    idle();
    check("t1_idle_av", aligned_valid, 1'b0);
    check("t1_idle_sync", sync, 1'b1);

    // Stream shifted 3 bits; output lags the sent symbol by one send.
    do_reset();
    send_sym(C);
    send_sym(C);
    send_sym(C);
    check("t2_sync_before", sync, 1'b0);
    send_sym(C);
    check("t2_sync", sync, 1'b1);
    check("t2_off", align_offset, 4'd3);
    check("t2_lock_word", aligned_word, C);
    send_sym(D);
    check("t2_c4_word", aligned_word, C);
    send_sym(D);
    check("t2_data_word", aligned_word, D);
    check("t2_data_comma", is_comma, 1'b0);
    check("t2_data_av", aligned_valid, 1'b1);
    check("t2_data_err", code_err, 1'b0);
    send_sym(D);

    // Four consecutive invalid words drop sync.
    send_sym(E);
    check("t3_good_err", code_err, 1'b0);
    for (int i = 0; i < 3; i++) begin
      send_sym(E);
      check($sformatf("t3_err%0d", i + 1), code_err, 1'b1);
      check($sformatf("t3_sync%0d", i + 1), sync, 1'b1);
    end
    send_sym(E);
    check("t3_err4", code_err, 1'b1);
    check("t3_av4", aligned_valid, 1'b1);
    check("t3_sync4", sync, 1'b0);
    send_sym(E);
    check("t3_hunt_err", code_err, 1'b0);
    check("t3_hunt_av", aligned_valid, 1'b0);

    // Relock, then isolated errors separated by good runs keep sync.
    send_sym(C);
    send_sym(C);
    send_sym(C);
    send_sym(C);
    check("t4_relock", sync, 1'b1);
    for (int r = 0; r < 5; r++) begin
      send_sym(E);
      send_sym(D);
      check($sformatf("t4_err_r%0d", r), code_err, 1'b1);
      check($sformatf("t4_sync_r%0d", r), sync, 1'b1);
      send_sym(D);
      send_sym(D);
      send_sym(D);
    end
    // Three errors, four good (count drops to two), then two more errors lose sync.
    send_sym(E);
    send_sym(E);
    send_sym(E);
    send_sym(D);
    check("t4_e3_sync", sync, 1'b1);
    send_sym(D);
    send_sym(D);
    send_sym(D);
    send_sym(E);
    send_sym(E);
    check("t4_e3b_sync", sync, 1'b1);
    check("t4_e3b_err", code_err, 1'b1);
    send_sym(D);
    check("t4_loss_sync", sync, 1'b0);
    check("t4_loss_err", code_err, 1'b1);

    // CONFIRM at offset 0, then a comma appears at offset 5.
    do_reset();
    beat(C, 1'b0);
    beat(C, 1'b0);
    beat(Y, 1'b0);
    check("t5_off0", align_offset, 4'd0);
    beat(Z, 1'b0);
    check("t5_off5", align_offset, 4'd5);
    check("t5_sync_a", sync, 1'b0);
    beat(Z, 1'b0);
    check("t5_sync_b", sync, 1'b0);
    beat(Z, 1'b0);
    check("t5_sync", sync, 1'b1);
    check("t5_word", aligned_word, C);
    check("t5_comma", is_comma, 1'b1);
    check("t5_lock_off", align_offset, 4'd5);

    // Realign on a beat, relock from retained history, then reset mid-stream.
    beat(Z, 1'b1);
    check("t6_ra_sync", sync, 1'b0);
    check("t6_ra_av", aligned_valid, 1'b0);
    beat(Z, 1'b0);
    check("t6_hunt_sync", sync, 1'b0);
    beat(Z, 1'b0);
    beat(Z, 1'b0);
    check("t6_relock", sync, 1'b1);
    do_reset();
    check_all_zero("t6_rst");
    beat(Z, 1'b0);
    beat(Z, 1'b0);
    beat(Z, 1'b0);
    check("t6_post_sync3", sync, 1'b0);
    beat(Z, 1'b0);
    check("t6_post_sync4", sync, 1'b1);
    check("t6_post_off", align_offset, 4'd5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
